mem_matrix_seq: RTL and testbench
=================================

Name: mem_matrix_seq

Overview:
- MEM-stage access sequencer between the EX/MEM pipeline register outputs and a single 32-bit data-memory port.
- Scalar loads/stores take one beat; 128-bit matrix loads/stores are split into four 32-bit beats.
- Freezes the pipeline (`stall`) until each access completes, and returns scalar or assembled matrix load data to writeback.

Parameters:
- BEATS, 4, 32-bit beats per matrix access (128/32); fixed by matrix width.
- TIMEOUT_CYCLES, 255, watchdog limit per beat (used only with MSEQ_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- me_mem_read  in  1  load request from EX/MEM
- me_mem_write  in  1  store request from EX/MEM
- me_matrix_op  in  1  1 = 128-bit matrix access, 0 = scalar
- me_func3_code  in  3  scalar size/sign code, passed to memory
- me_alu_o  in  32  effective address
- me_regs_data2  in  32  scalar store data
- me_matrix_o  in  128  matrix store data
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  32  beat address
- dmem_wdata  out  32  beat write data
- dmem_size  out  3  func3 for scalar; 3'b010 (word) for matrix beats
- dmem_ready  in  1  memory accepts/completes beat this cycle
- dmem_rdata  in  32  read data, valid when dmem_req&dmem_ready
- stall  out  1  freeze IF..EX/MEM registers
- done  out  1  one-cycle completion pulse
- ld_data  out  32  scalar load result
- ld_matrix  out  128  assembled matrix load result
- err  out  1  watchdog timeout (sticky until reset)

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; beat counter 0; all outputs 0; latched address/data cleared.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - access = me_mem_read | me_mem_write.
  - If access: stall=1 combinationally in the same cycle. Latch kind, address, store data and func3. Next state XFER.
  - Otherwise stall=0.
  - If both read and write are set, the access is treated as a write.
- XFER:
  - dmem_req=1 and stall=1.
  - Request fields stay stable until dmem_ready=1. dmem_ready is ignored when dmem_req=0.
  - On req&ready with a read: capture dmem_rdata. Scalar → ld_data. Matrix → ld_matrix[32k+31:32k].
  - Scalar access: one beat, then DONE.
  - Matrix access: beat k = 0..3, then DONE after beat 3.
- Matrix addressing:
  - base = {addr[31:4], 4'b0}; low 4 address bits are ignored.
  - Beat k: dmem_addr = base + 4k; dmem_wdata = me_matrix_o[32k+31:32k] (little-endian, beat 0 = least-significant word).
  - No wrap handling: base 0xFFFFFFF0 gives beat addresses F0, F4, F8, FC.
- Scalar addressing: dmem_addr = me_alu_o unmodified; dmem_wdata = me_regs_data2.
- DONE:
  - stall=0, done=1 for exactly one cycle; EX/MEM advances on this edge.
  - Never starts a new access, which prevents re-issuing the frozen instruction.
  - Next state IDLE.
- Load result retention: ld_data and ld_matrix hold their values until the next load completes. Stores leave them unchanged.
- Latency with zero-wait memory (ready=1): scalar 3 cycles of which 2 stalled; matrix 6 cycles of which 5 stalled.
- Reset during XFER: the request drops immediately, and the partial ld_matrix is cleared.

Optional Feature:
- Macro: MSEQ_TIMEOUT_EN.
- Defined:
  - Per-beat wait counter, cleared on each accepted beat.
  - If dmem_req is held TIMEOUT_CYCLES cycles without ready: err=1 (sticky), the beat is abandoned, and the FSM goes to DONE.
  - Abandoned read data for the beat = 32'h0.
- Undefined: no counter; err tied 0; the FSM waits indefinitely.

Test Plan:
- Scalar store, addr 0x100, data 0xDEADBEEF, func3 010, ready=1 → one beat: we=1, addr 0x100, size 010; stall high for 2 cycles; done pulses in cycle 3.
- Matrix store, addr 0x207 → beats to 0x200/204/208/20C carrying words 0..3 of 128'h33333333_22222222_11111111_00000000, i.e. 0x00000000, 0x11111111, 0x22222222, 0x33333333; stall 5 cycles.
- Matrix load at 0x40, rdata per beat 0xA0,0xA1,0xA2,0xA3, ready low 2 cycles on beat 1 → ld_matrix = 128'h000000A3_000000A2_000000A1_000000A0; fields stable during wait; stall 7 cycles.
- Back-to-back scalar loads (0x10 then 0x14) → exactly two requests; no re-issue of 0x10 in the DONE cycle.
- rst pulsed low mid-beat 2 of a matrix store → dmem_req, stall, ld_matrix = 0 immediately; after release, IDLE with no request.
- With MSEQ_TIMEOUT_EN, ready held 0 → err=1 after 255 cycles, done pulses, stall drops.

Source files
------------

// File: rtl/mem_matrix_seq.sv
// MEM-stage access sequencer: scalar accesses take one 32-bit beat, matrix accesses four.
// Optional per-beat watchdog is enabled by defining MSEQ_TIMEOUT_EN.
module mem_matrix_seq #(
  parameter int BEATS = 4
`ifdef MSEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         me_mem_read,
  input  logic         me_mem_write,
  input  logic         me_matrix_op,
  input  logic [2:0]   me_func3_code,
  input  logic [31:0]  me_alu_o,
  input  logic [31:0]  me_regs_data2,
  input  logic [127:0] me_matrix_o,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [31:0]  dmem_addr,
  output logic [31:0]  dmem_wdata,
  output logic [2:0]   dmem_size,
  input  logic         dmem_ready,
  input  logic [31:0]  dmem_rdata,
  output logic         stall,
  output logic         done,
  output logic [31:0]  ld_data,
  output logic [127:0] ld_matrix,
  output logic         err
);

  localparam int BW = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic           matrix_q, matrix_d;
  logic           we_q, we_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    sdata_q, sdata_d;
  logic [127:0]   mdata_q, mdata_d;
  logic [2:0]     func3_q, func3_d;
  logic [31:0]    ld_data_q, ld_data_d;
  logic [127:0]   ld_matrix_q, ld_matrix_d;
  logic           err_q, err_d;

  logic           access_s;
  logic           xfer_s;
  logic           last_beat_s;
  logic [BW+4:0]  lane_s;

`ifdef MSEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0]  wait_q, wait_d;
  logic           timeout_s;
`endif

  assign access_s    = me_mem_read | me_mem_write;
  assign xfer_s      = (state_q == XFER);
  assign last_beat_s = !matrix_q || (beat_q == BW'(BEATS - 1));
  assign lane_s      = {beat_q, 5'b00000};

`ifdef MSEQ_TIMEOUT_EN
  assign timeout_s = xfer_s && !dmem_ready && (wait_q == WW'(TIMEOUT_CYCLES - 1));
`endif

  // Memory-port drive, gated so the bus reads zero whenever no beat is in flight.
  always_comb begin
    dmem_req   = xfer_s;
    dmem_we    = xfer_s & we_q;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;
    dmem_size  = 3'b000;
    if (xfer_s) begin
      if (matrix_q) begin
        dmem_addr  = {addr_q[31:4], 4'h0} + {{(30-BW){1'b0}}, beat_q, 2'b00};
        dmem_wdata = mdata_q[lane_s +: 32];
        dmem_size  = 3'b010;
      end else begin
        dmem_addr  = addr_q;
        dmem_wdata = sdata_q;
        dmem_size  = func3_q;
      end
    end else begin
      dmem_addr  = 32'h0;
    end
  end

  // Pipeline handshake; stall is qualified by rst so it drops the moment reset asserts.
  always_comb begin
    stall     = rst & (((state_q == IDLE) & access_s) | xfer_s);
    done      = (state_q == DONE);
    ld_data   = ld_data_q;
    ld_matrix = ld_matrix_q;
    err       = err_q;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    matrix_d    = matrix_q;
    we_d        = we_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    mdata_d     = mdata_q;
    func3_d     = func3_q;
    ld_data_d   = ld_data_q;
    ld_matrix_d = ld_matrix_q;
    err_d       = err_q;
`ifdef MSEQ_TIMEOUT_EN
    wait_d      = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (access_s) begin
          state_d  = XFER;
          beat_d   = {BW{1'b0}};
          matrix_d = me_matrix_op;
          we_d     = me_mem_write;
          addr_d   = me_alu_o;
          sdata_d  = me_regs_data2;
          mdata_d  = me_matrix_o;
          func3_d  = me_func3_code;
`ifdef MSEQ_TIMEOUT_EN
          wait_d   = {WW{1'b0}};
`endif
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (dmem_ready) begin
          if (we_q) begin
            ld_data_d = ld_data_q;
          end else if (matrix_q) begin
            ld_matrix_d[lane_s +: 32] = dmem_rdata;
          end else begin
            ld_data_d = dmem_rdata;
          end
`ifdef MSEQ_TIMEOUT_EN
          wait_d = {WW{1'b0}};
`endif
          if (last_beat_s) begin
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
`ifdef MSEQ_TIMEOUT_EN
          if (timeout_s) begin
            // Abandoned read beats return zero in their slot.
            err_d   = 1'b1;
            state_d = DONE;
            if (we_q) begin
              ld_data_d = ld_data_q;
            end else if (matrix_q) begin
              ld_matrix_d[lane_s +: 32] = 32'h0;
            end else begin
              ld_data_d = 32'h0;
            end
          end else begin
            wait_d = wait_q + 1'b1;
          end
`else
          state_d = XFER;
`endif
        end
      end
      DONE: begin
        // Never launch here: the frozen instruction is still on the EX/MEM outputs.
        state_d = IDLE;
        beat_d  = {BW{1'b0}};
      end
      default: begin
        state_d = IDLE;
        beat_d  = {BW{1'b0}};
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= {BW{1'b0}};
      matrix_q    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      sdata_q     <= 32'h0;
      mdata_q     <= 128'h0;
      func3_q     <= 3'b000;
      ld_data_q   <= 32'h0;
      ld_matrix_q <= 128'h0;
      err_q       <= 1'b0;
`ifdef MSEQ_TIMEOUT_EN
      wait_q      <= {WW{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      matrix_q    <= matrix_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      mdata_q     <= mdata_d;
      func3_q     <= func3_d;
      ld_data_q   <= ld_data_d;
      ld_matrix_q <= ld_matrix_d;
      err_q       <= err_d;
`ifdef MSEQ_TIMEOUT_EN
      wait_q      <= wait_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_matrix_seq.sv
// Scoreboard bench for mem_matrix_seq: expected beats are queued at issue time and
// checked by an independent monitor whenever a beat is accepted on the memory port.
module tb_mem_matrix_seq;

  logic         clk;
  logic         rst;
  logic         me_mem_read;
  logic         me_mem_write;
  logic         me_matrix_op;
  logic [2:0]   me_func3_code;
  logic [31:0]  me_alu_o;
  logic [31:0]  me_regs_data2;
  logic [127:0] me_matrix_o;
  logic         dmem_req;
  logic         dmem_we;
  logic [31:0]  dmem_addr;
  logic [31:0]  dmem_wdata;
  logic [2:0]   dmem_size;
  logic         dmem_ready;
  logic [31:0]  dmem_rdata;
  logic         stall;
  logic         done;
  logic [31:0]  ld_data;
  logic [127:0] ld_matrix;
  logic         err;
  logic         rdy;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    stall_total = 0;
  int    done_total = 0;
  int    beat_total = 0;

  mem_matrix_seq dut (
    .clk(clk), .rst(rst),
    .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
    .me_matrix_op(me_matrix_op), .me_func3_code(me_func3_code),
    .me_alu_o(me_alu_o), .me_regs_data2(me_regs_data2), .me_matrix_o(me_matrix_o),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_size(dmem_size),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall(stall), .done(done), .ld_data(ld_data), .ld_matrix(ld_matrix), .err(err)
  );

  // Memory model: read data 0xA0 + word index within a 16-byte block.
  assign dmem_ready = rdy;
  assign dmem_rdata = 32'h000000A0 + {30'd0, dmem_addr[3:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: counts stall/done cycles and checks each accepted beat against the queue.
  always @(negedge clk) begin
    if (stall) stall_total++;
    if (done) done_total++;
    if (rst && dmem_req && dmem_ready) begin
      beat_total++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat got addr=%h we=%b expected no beat", dmem_addr, dmem_we);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat", {60'd0, dmem_we, dmem_addr, dmem_wdata, dmem_size},
            {60'd0, e.we, e.addr, e.wdata, e.size});
      end
    end
  end

  task automatic idle_inputs();
    me_mem_read   = 1'b0;
    me_mem_write  = 1'b0;
    me_matrix_op  = 1'b0;
    me_func3_code = 3'b000;
    me_alu_o      = 32'h0;
    me_regs_data2 = 32'h0;
    me_matrix_o   = 128'h0;
  endtask

  // Issues one access, waits for done, then advances to the next edge (+1).
  task automatic access(input logic rd, input logic wr, input logic mx, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d2, input logic [127:0] md,
                        input int exp_stall, input string nm);
    int s0, d0;
    bit seen;
    beat_t b;
    if (mx) begin
      for (int k = 0; k < 4; k++) begin
        b.we    = wr;
        b.addr  = {a[31:4], 4'h0} + 32'(k * 4);
        b.wdata = md[k*32 +: 32];
        b.size  = 3'b010;
        exp_q.push_back(b);
      end
    end else begin
      b.we    = wr;
      b.addr  = a;
      b.wdata = d2;
      b.size  = f3;
      exp_q.push_back(b);
    end
    s0 = stall_total;
    d0 = done_total;
    me_mem_read   = rd;
    me_mem_write  = wr;
    me_matrix_op  = mx;
    me_func3_code = f3;
    me_alu_o      = a;
    me_regs_data2 = d2;
    me_matrix_o   = md;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, {127'd0, seen}, 128'd1);
    chk({nm, "_stall_in_done"}, {126'd0, stall, dmem_req}, 128'd0);
    @(posedge clk);
    #1;
    chk({nm, "_stall_cycles"}, 128'(stall_total - s0), 128'(exp_stall));
    chk({nm, "_done_pulses"}, 128'(done_total - d0), 128'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    beat_t b;
    rst = 1'b0;
    rdy = 1'b1;
    idle_inputs();
    #12;
    chk("reset_outputs", {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_size, stall, done, err},
        128'd0);
    chk("reset_ld", {ld_data, ld_matrix[95:0]}, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Scalar store: one beat, two stall cycles, loads untouched.
    access(1'b0, 1'b1, 1'b0, 3'b010, 32'h00000100, 32'hDEADBEEF, 128'h0, 2, "sst");
    idle_inputs();
    chk("sst_ld_kept", {96'd0, ld_data}, 128'd0);

    // Matrix store at unaligned address: base forced to 0x200.
    access(1'b0, 1'b1, 1'b1, 3'b000, 32'h00000207, 32'h0,
           128'h33333333_22222222_11111111_00000000, 5, "mst");
    idle_inputs();

    // Matrix load with two wait cycles on beat 1.
    fork
      access(1'b1, 1'b0, 1'b1, 3'b000, 32'h00000040, 32'h0, 128'h0, 7, "mld");
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        rdy = 1'b0;
        @(negedge clk);
        chk("wait_fields_1", {63'd0, dmem_req, dmem_we, dmem_addr, dmem_size, 28'd0},
            {63'd0, 1'b1, 1'b0, 32'h00000044, 3'b010, 28'd0});
        @(posedge clk); #1;
        @(negedge clk);
        chk("wait_fields_2", {63'd0, dmem_req, dmem_we, dmem_addr, dmem_size, 28'd0},
            {63'd0, 1'b1, 1'b0, 32'h00000044, 3'b010, 28'd0});
        @(posedge clk); #1;
        rdy = 1'b1;
      end
    join
    idle_inputs();
    chk("mld_result", ld_matrix, 128'h000000A3_000000A2_000000A1_000000A0);

    // Back-to-back scalar loads; an extra beat would be flagged by the monitor.
    access(1'b1, 1'b0, 1'b0, 3'b100, 32'h00000010, 32'h0, 128'h0, 2, "sld0");
    chk("sld0_data", {96'd0, ld_data}, {96'd0, 32'h000000A0});
    access(1'b1, 1'b0, 1'b0, 3'b100, 32'h00000014, 32'h0, 128'h0, 2, "sld1");
    idle_inputs();
    chk("sld1_data", {96'd0, ld_data}, {96'd0, 32'h000000A1});
    chk("sld_matrix_kept", ld_matrix, 128'h000000A3_000000A2_000000A1_000000A0);

    // Reset asserted while beat 2 of a matrix store is on the bus.
    for (int k = 0; k < 2; k++) begin
      b.we    = 1'b1;
      b.addr  = 32'h00000300 + 32'(k * 4);
      b.wdata = (k == 0) ? 32'hAAAAAAAA : 32'hBBBBBBBB;
      b.size  = 3'b010;
      exp_q.push_back(b);
    end
    me_mem_write = 1'b1;
    me_matrix_op = 1'b1;
    me_alu_o     = 32'h00000300;
    me_matrix_o  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_pre_beat2", {95'd0, dmem_req, dmem_addr}, {95'd0, 1'b1, 32'h00000308});
    #1;
    rst = 1'b0;
    #1;
    chk("rst_immediate", {124'd0, dmem_req, stall, done, err}, 128'd0);
    chk("rst_ld_matrix", ld_matrix, 128'd0);
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {125'd0, dmem_req, stall, done}, 128'd0);
    end

`ifdef MSEQ_TIMEOUT_EN
    begin
      bit seen;
      rdy = 1'b0;
      @(posedge clk); #1;
      me_mem_read = 1'b1;
      me_alu_o    = 32'h00000080;
      seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      chk("tmo_done_seen", {127'd0, seen}, 128'd1);
      chk("tmo_err_stall", {126'd0, err, stall}, {126'd0, 1'b1, 1'b0});
      @(posedge clk); #1;
      idle_inputs();
      rdy = 1'b1;
      @(negedge clk);
      chk("tmo_err_sticky", {126'd0, err, dmem_req}, {126'd0, 1'b1, 1'b0});
    end
`else
    chk("err_tied_low", {127'd0, err}, 128'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    chk("beat_count", 128'(beat_total), 128'd13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
